// File: rtl/klein_64_dec.sv
// KLEIN-64 block decryptor, byte-serial I/O.
// A block is loaded over 8 cycles, the key is expanded forward to sk13 in
// 12 cycles, then 12 inverse rounds walk the key schedule back down to sk1.
// The plaintext is then streamed out over 8 cycles, MSB byte first.
// Fixed 40-cycle block period; ready in cycles 32..39 after start.
module klein_64_dec #(
    parameter int NR = 12
) (
    input  logic       ck,
    input  logic       rst,
    input  logic       start,
    input  logic [0:7] inp,
    input  logic [0:7] key,
    output logic       ready,
    output logic [0:7] out
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        EXPAND,
        ROUND,
        OUT
    } state_t;

    state_t      st, st_nx;
    logic [3:0]  cnt, cnt_nx;   // byte phase in LOAD / OUT
    logic [3:0]  rnd, rnd_nx;   // key-schedule / round index i
    logic [63:0] x, x_nx;       // cipher state, byte 0 in [63:56]
    logic [63:0] k, k_nx;       // current round key
    logic [7:0]  bsel;

    // ------------------------------------------------------------------
    // Primitives
    // ------------------------------------------------------------------

    // KLEIN S-box; an involution, so it serves both directions.
    function automatic logic [3:0] sb(input logic [3:0] v);
        logic [3:0] r;
        case (v)
            4'h0: r = 4'h7;
            4'h1: r = 4'h4;
            4'h2: r = 4'hA;
            4'h3: r = 4'h9;
            4'h4: r = 4'h1;
            4'h5: r = 4'hF;
            4'h6: r = 4'hB;
            4'h7: r = 4'h0;
            4'h8: r = 4'hC;
            4'h9: r = 4'h3;
            4'hA: r = 4'h2;
            4'hB: r = 4'h6;
            4'hC: r = 4'h8;
            4'hD: r = 4'hE;
            4'hE: r = 4'hD;
            default: r = 4'h5;
        endcase
        return r;
    endfunction

    function automatic logic [15:0] sb16(input logic [15:0] v);
        logic [15:0] r;
        for (int n = 0; n < 4; n++) r[4*n +: 4] = sb(v[4*n +: 4]);
        return r;
    endfunction

    function automatic logic [63:0] sb64(input logic [63:0] v);
        logic [63:0] r;
        for (int n = 0; n < 16; n++) r[4*n +: 4] = sb(v[4*n +: 4]);
        return r;
    endfunction

    // Multiply by x in GF(2^8) mod x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xt(input logic [7:0] v);
        return {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
    endfunction

    // Multiply by a 4-bit constant m (sum of x^0..x^3 terms).
    function automatic logic [7:0] gm(input logic [7:0] v, input logic [3:0] m);
        logic [7:0] v2, v4, v8, r;
        v2 = xt(v);
        v4 = xt(v2);
        v8 = xt(v4);
        r  = (m[0] ? v  : 8'h00) ^ (m[1] ? v2 : 8'h00) ^
             (m[2] ? v4 : 8'h00) ^ (m[3] ? v8 : 8'h00);
        return r;
    endfunction

    // AES InvMixColumns on one 32-bit column (byte 0 in the MSBs).
    function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
        logic [7:0] s0, s1, s2, s3;
        logic [7:0] r0, r1, r2, r3;
        s0 = c[31:24];
        s1 = c[23:16];
        s2 = c[15:8];
        s3 = c[7:0];
        r0 = gm(s0, 4'd14) ^ gm(s1, 4'd11) ^ gm(s2, 4'd13) ^ gm(s3, 4'd9);
        r1 = gm(s0, 4'd9)  ^ gm(s1, 4'd14) ^ gm(s2, 4'd11) ^ gm(s3, 4'd13);
        r2 = gm(s0, 4'd13) ^ gm(s1, 4'd9)  ^ gm(s2, 4'd14) ^ gm(s3, 4'd11);
        r3 = gm(s0, 4'd11) ^ gm(s1, 4'd13) ^ gm(s2, 4'd9)  ^ gm(s3, 4'd14);
        return {r0, r1, r2, r3};
    endfunction

    // Forward key step sk(i) -> sk(i+1).
    function automatic logic [63:0] ks_fwd(input logic [63:0] kv, input logic [3:0] i);
        logic [31:0] ra, rb, na, nb;
        ra = {kv[55:32], kv[63:56]};
        rb = {kv[23:0],  kv[31:24]};
        na = rb;
        nb = ra ^ rb;
        na[15:8] = na[15:8] ^ {4'h0, i};
        nb[23:8] = sb16(nb[23:8]);
        return {na, nb};
    endfunction

    // Inverse key step sk(i+1) -> sk(i); undoes ks_fwd in reverse order.
    function automatic logic [63:0] ks_inv(input logic [63:0] kv, input logic [3:0] i);
        logic [31:0] na, nb, ra, rb;
        na = kv[63:32];
        nb = kv[31:0];
        nb[23:8] = sb16(nb[23:8]);
        na[15:8] = na[15:8] ^ {4'h0, i};
        rb = na;
        ra = na ^ nb;
        return {ra[7:0], ra[31:8], rb[7:0], rb[31:8]};
    endfunction

    // One inverse round without the key addition.
    function automatic logic [63:0] dec_core(input logic [63:0] v);
        logic [63:0] t;
        t = {inv_mix_col(v[63:32]), inv_mix_col(v[31:0])};
        t = {t[15:0], t[63:16]};
        return sb64(t);
    endfunction

    // ------------------------------------------------------------------
    // Datapath / FSM
    // ------------------------------------------------------------------

    // State register with synchronous reset.
    always_ff @(posedge ck) begin
        if (rst) begin
            st  <= IDLE;
            cnt <= 4'd0;
            rnd <= 4'd0;
            x   <= 64'h0;
            k   <= 64'h0;
        end else begin
            st  <= st_nx;
            cnt <= cnt_nx;
            rnd <= rnd_nx;
            x   <= x_nx;
            k   <= k_nx;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        logic [63:0] kn;
        st_nx  = st;
        cnt_nx = cnt;
        rnd_nx = rnd;
        x_nx   = x;
        k_nx   = k;
        kn     = 64'h0;
        case (st)
            IDLE: begin
                if (start) begin
                    x_nx   = {56'h0, inp};
                    k_nx   = {56'h0, key};
                    cnt_nx = 4'd1;
                    st_nx  = LOAD;
                end
            end
            LOAD: begin
                x_nx   = {x[55:0], inp};
                k_nx   = {k[55:0], key};
                cnt_nx = cnt + 4'd1;
                if (cnt == 4'd7) begin
                    cnt_nx = 4'd0;
                    rnd_nx = 4'd1;
                    st_nx  = EXPAND;
                end
            end
            EXPAND: begin
                kn   = ks_fwd(k, rnd);
                k_nx = kn;
                if (rnd == 4'(NR)) begin
                    // sk13 is the final whitening key of encryption.
                    x_nx  = x ^ kn;
                    st_nx = ROUND;
                end else begin
                    rnd_nx = rnd + 4'd1;
                end
            end
            ROUND: begin
                kn     = ks_inv(k, rnd);
                k_nx   = kn;
                x_nx   = dec_core(x) ^ kn;
                rnd_nx = rnd - 4'd1;
                if (rnd == 4'd1) begin
                    cnt_nx = 4'd0;
                    st_nx  = OUT;
                end
            end
            OUT: begin
                cnt_nx = cnt + 4'd1;
                if (cnt == 4'd7) begin
                    cnt_nx = 4'd0;
                    st_nx  = IDLE;
                end
            end
            default: st_nx = IDLE;
        endcase
    end

    // Output byte decoded from registered state only.
    always_comb begin
        bsel  = x[{~cnt[2:0], 3'b000} +: 8];
        ready = (st == OUT);
        out   = ready ? bsel : 8'h00;
    end

endmodule

// File: tb/tb_klein_64_dec.sv
// Bench for klein_64_dec: directed known-answer vectors, start/reset
// corner cases and a loopback through a behavioural KLEIN-64 encryptor.
// Stimulus pushes expected (cycle, byte) pairs; a monitor pops and checks.
module tb_klein_64_dec;

    logic       ck = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [0:7] inp = 8'h00;
    logic [0:7] key = 8'h00;
    logic       ready;
    logic [0:7] out;

    klein_64_dec #(.NR(12)) dut (
        .ck(ck), .rst(rst), .start(start), .inp(inp), .key(key),
        .ready(ready), .out(out)
    );

    always #5 ck = ~ck;

    int cyc = 0;
    always @(posedge ck) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [7:0] d;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   tests = 0;
    int   fails = 0;
    bit   mon_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, req);
        end
    endtask

    // ---------------- behavioural encryptor ----------------
    function automatic logic [3:0] f_sb(input logic [3:0] v);
        logic [3:0] t [16] = '{4'h7, 4'h4, 4'hA, 4'h9, 4'h1, 4'hF, 4'hB, 4'h0,
                               4'hC, 4'h3, 4'h2, 4'h6, 4'h8, 4'hE, 4'hD, 4'h5};
        return t[v];
    endfunction

    function automatic logic [7:0] f_x2(input logic [7:0] v);
        return {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] f_mix(input logic [31:0] c);
        logic [7:0] b [4];
        logic [7:0] r [4];
        for (int n = 0; n < 4; n++) b[n] = c[31-8*n -: 8];
        for (int n = 0; n < 4; n++)
            r[n] = f_x2(b[n]) ^ f_x2(b[(n+1)%4]) ^ b[(n+1)%4] ^ b[(n+2)%4] ^ b[(n+3)%4];
        return {r[0], r[1], r[2], r[3]};
    endfunction

    function automatic logic [63:0] f_ks(input logic [63:0] kv, input int i);
        logic [31:0] a, b, na, nb;
        a  = kv[63:32];
        b  = kv[31:0];
        a  = {a[23:0], a[31:24]};
        b  = {b[23:0], b[31:24]};
        na = b;
        nb = a ^ b;
        na[15:8] = na[15:8] ^ 8'(i);
        for (int n = 2; n < 6; n++) nb[4*n +: 4] = f_sb(nb[4*n +: 4]);
        return {na, nb};
    endfunction

    function automatic logic [63:0] f_enc(input logic [63:0] kv, input logic [63:0] p);
        logic [63:0] s, kk;
        s  = p;
        kk = kv;
        for (int i = 1; i <= 12; i++) begin
            s = s ^ kk;
            for (int n = 0; n < 16; n++) s[4*n +: 4] = f_sb(s[4*n +: 4]);
            s  = {s[47:0], s[63:48]};
            s  = {f_mix(s[63:32]), f_mix(s[31:0])};
            kk = f_ks(kk, i);
        end
        return s ^ kk;
    endfunction

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge ck);
        #1;
    endtask

    // Runs len cycles starting now: start in cycle 0, bytes in 0..7,
    // extra start pulses at pa/pb, rst in cycle rst_at (-1 = none).
    task automatic blk(input logic [63:0] kv, input logic [63:0] ct, input logic [63:0] pt,
                       input bit push, input int pa, input int pb, input int rst_at, input int len);
        if (push)
            for (int j = 0; j < 8; j++) q.push_back('{cyc + 32 + j, pt[63-8*j -: 8]});
        for (int j = 0; j < len; j++) begin
            start = (j == 0) || (j == pa) || (j == pb);
            rst   = (j == rst_at);
            if (j < 8) begin
                inp = ct[63-8*j -: 8];
                key = kv[63-8*j -: 8];
            end else begin
                inp = 8'($urandom);
                key = 8'($urandom);
            end
            tick();
        end
        start = 1'b0;
        rst   = 1'b0;
    endtask

    // ---------------- monitor ----------------
    always @(negedge ck) begin
        if (mon_en) begin
            if (ready) begin
                if (q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_ready cyc=%0d got=%h want=no_output", cyc, out);
                end else begin
                    e = q.pop_front();
                    check("ready_cycle", 64'(cyc), 64'(e.cyc));
                    check("out_byte", 64'(out), 64'(e.d));
                end
            end else begin
                check("out_zero_idle", 64'(out), 64'h0);
                if (q.size() != 0 && q[0].cyc <= cyc) begin
                    e = q.pop_front();
                    tests++;
                    fails++;
                    $display("FAIL missing_ready cyc=%0d got=ready0 want=byte %h at %0d", cyc, e.d, e.cyc);
                end
            end
        end
    end

    // ---------------- sequence ----------------
    initial begin
        logic [63:0] kr, pr;
        rst = 1'b1;
        repeat (3) tick();
        check("reset_ready", 64'(ready), 64'h0);
        check("reset_out", 64'(out), 64'h0);
        rst    = 1'b0;
        mon_en = 1'b1;

        // Start accepted in the first cycle after reset; stray starts at 5 and 25.
        blk(64'h0000000000000000, 64'hCDC0B51F14722BBE, 64'hFFFFFFFFFFFFFFFF, 1, 5, 25, -1, 40);
        // Back-to-back at cycle 40.
        blk(64'hFFFFFFFFFFFFFFFF, 64'h6456764E8602E154, 64'h0000000000000000, 1, -1, -1, -1, 40);
        blk(64'h1234567890ABCDEF, 64'h592356C4997176C8, 64'hFFFFFFFFFFFFFFFF, 1, -1, -1, -1, 40);
        blk(64'h0000000000000000, 64'h629F9D6DFF95800E, 64'h1234567890ABCDEF, 1, -1, -1, -1, 40);

        // Abort at cycle 15, restart at 17: ready from cycle 49 only.
        blk(64'h1234567890ABCDEF, 64'h592356C4997176C8, 64'h0, 0, -1, -1, 15, 17);
        blk(64'h0000000000000000, 64'h629F9D6DFF95800E, 64'h1234567890ABCDEF, 1, -1, -1, -1, 40);

        // Loopback against the behavioural encryptor.
        for (int n = 0; n < 1000; n++) begin
            kr = {$urandom, $urandom};
            pr = {$urandom, $urandom};
            blk(kr, f_enc(kr, pr), pr, 1, -1, -1, -1, 40);
        end

        repeat (45) tick();
        check("queue_drained", 64'(q.size()), 64'h0);
        mon_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
